// File: rtl/conv3x3_stream_if.sv
// Pixel-in / result-out stream bundle for conv3x3_stream, including the kernel write port.
// The slave modport is the engine's view; the master modport drives it.
interface conv3x3_stream_if #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 4
);
  localparam int OUT_W = DATA_W + COEF_W + 5;

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_sof;
  logic [DATA_W-1:0]        in_data;
  logic                     coef_wr;
  logic [3:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_eol;

  modport slave (
    input  in_valid, in_sof, in_data, coef_wr, coef_addr, coef_data, out_ready,
    output in_ready, out_valid, out_data, out_eol
  );

  modport master (
    output in_valid, in_sof, in_data, coef_wr, coef_addr, coef_data, out_ready,
    input  in_ready, out_valid, out_data, out_eol
  );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with a runtime-loadable kernel, valid/ready flow control and frame sync.
// Optional macro CONV3X3_ABS_EN: output the saturated magnitude instead of the raw signed sum.
module conv3x3_stream #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 1280,
  parameter int COEF_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  conv3x3_stream_if.slave bus
);
  localparam int OUT_W  = DATA_W + COEF_W + 5;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int COL_W  = $clog2(IMG_W);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic signed [OUT_W-1:0] SUM_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] SUM_MAX = ~SUM_MIN;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t                   state_q, state_d;
  logic [COL_W-1:0]         col_q, col_d, pix_col, nxt_col;
  logic [1:0]               row_q, row_d, pix_row;
  logic [DATA_W-1:0]        line0_mem [IMG_W];
  logic [DATA_W-1:0]        line1_mem [IMG_W];
  logic [DATA_W-1:0]        rd0_q, rd1_q;
  logic [DATA_W-1:0]        win_q [6];
  logic [DATA_W-1:0]        new_col [3];
  logic [DATA_W-1:0]        tap [9];
  logic signed [COEF_W-1:0] shadow_q [9];
  logic signed [COEF_W-1:0] shadow_d [9];
  logic signed [COEF_W-1:0] active_q [9];
  logic signed [PROD_W-1:0] prod [9];
  logic signed [OUT_W-1:0]  sum, result;
  logic signed [OUT_W-1:0]  out_data_q;
  logic                     out_valid_q, out_eol_q;
  logic                     beat, take, emit;

  function automatic logic signed [COEF_W-1:0] sobel_v(input int k);
    int w;
    w = (k / 3 == 1) ? 2 : 1;
    case (k % 3)
      0:       return COEF_W'(w);
      2:       return COEF_W'(-w);
      default: return '0;
    endcase
  endfunction

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_eol   = out_eol_q;

  // Idle beats without in_sof are consumed but otherwise ignored.
  assign beat    = bus.in_valid && bus.in_ready;
  assign take    = beat && (bus.in_sof || state_q != IDLE);
  assign pix_col = bus.in_sof ? '0 : col_q;
  assign pix_row = bus.in_sof ? 2'd0 : row_q;
  assign nxt_col = (pix_col == LAST_COL) ? '0 : pix_col + 1'b1;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    emit    = 1'b0;
    if (take) begin
      col_d = nxt_col;
      row_d = (pix_col == LAST_COL && pix_row != 2'd2) ? pix_row + 2'd1 : pix_row;
      case (state_q)
        IDLE: state_d = FILL;
        FILL: if (pix_col == LAST_COL && pix_row == 2'd1) state_d = RUN;
        RUN: begin
          if (bus.in_sof) state_d = FILL;
          else if (pix_row == 2'd2 && pix_col >= COL_W'(2)) emit = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Column entering the window: row r=0 is two lines back, r=2 is the live pixel.
  assign new_col[0] = rd1_q;
  assign new_col[1] = rd0_q;
  assign new_col[2] = bus.in_data;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_tap
      assign tap[3*gi]     = win_q[2*gi];
      assign tap[3*gi + 1] = win_q[2*gi + 1];
      assign tap[3*gi + 2] = new_col[gi];
    end
    for (genvar gi = 0; gi < 9; gi++) begin : g_mac
      assign shadow_d[gi] = (bus.coef_wr && bus.coef_addr == 4'(gi)) ? bus.coef_data : shadow_q[gi];
      assign prod[gi] = PROD_W'($signed({1'b0, tap[gi]})) * PROD_W'(active_q[gi]);
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int k = 0; k < 9; k++) sum = sum + OUT_W'(prod[k]);
  end

`ifdef CONV3X3_ABS_EN
  always_comb begin
    if (sum == SUM_MIN)  result = SUM_MAX;
    else if (sum < 0)    result = -sum;
    else                 result = sum;
  end
`else
  assign result = sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_eol_q   <= 1'b0;
      for (int k = 0; k < 6; k++) win_q[k] <= '0;
      for (int k = 0; k < 9; k++) begin
        shadow_q[k] <= sobel_v(k);
        active_q[k] <= sobel_v(k);
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      for (int k = 0; k < 9; k++) shadow_q[k] <= shadow_d[k];
      if (beat && bus.in_sof) begin
        for (int k = 0; k < 9; k++) active_q[k] <= shadow_d[k];
      end
      if (take) begin
        for (int r = 0; r < 3; r++) begin
          win_q[2*r]     <= win_q[2*r + 1];
          win_q[2*r + 1] <= new_col[r];
        end
      end
      if (beat) begin
        out_valid_q <= emit;
        if (emit) begin
          out_data_q <= result;
          out_eol_q  <= (pix_col == LAST_COL);
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Line buffers are read one column ahead so the registered read lines up with the next beat.
  always_ff @(posedge clk) begin
    if (take) begin
      line0_mem[pix_col] <= bus.in_data;
      line1_mem[pix_col] <= rd0_q;
      rd0_q <= line0_mem[nxt_col];
      rd1_q <= line1_mem[nxt_col];
    end
  end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream: table-driven frames, hand-written corner cases and a
// randomized phase scored against a frame-array reference model.
module tb_conv3x3_stream;
  localparam int DATA_W = 12;
  localparam int IMG_W  = 8;
  localparam int COEF_W = 4;
  localparam int OUT_W  = DATA_W + COEF_W + 5;
`ifdef CONV3X3_ABS_EN
  localparam int RAMP_EXP = 80;
`else
  localparam int RAMP_EXP = -80;
`endif

  typedef struct { int data; bit eol; } res_t;
  typedef struct { bit sof; bit wr_ones; int mode; int rows; int exp_val; int exp_cnt; } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv3x3_stream_if #(.DATA_W(DATA_W), .COEF_W(COEF_W)) bus ();
  conv3x3_stream #(.DATA_W(DATA_W), .IMG_W(IMG_W), .COEF_W(COEF_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int shadow [9];
  int act [9];
  int img [3][IMG_W];
  bit in_frame;
  int mrow, mcol;
  res_t exp_q [$];
  int xfer_cnt, xfer_total, eol_cnt, tbl_bad, tbl_exp;
  bit tbl_on, prev_stall, last_beat;
  vec_t tbl [4];

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic model_reset();
    int sob [9];
    sob = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    for (int k = 0; k < 9; k++) begin shadow[k] = sob[k]; act[k] = sob[k]; end
    in_frame = 1'b0; mrow = 0; mcol = 0;
    exp_q.delete();
  endtask

  task automatic model_beat(input int pix, input bit sof);
    int s;
    res_t r;
    if (sof) begin act = shadow; in_frame = 1'b1; mrow = 0; mcol = 0; end
    if (!in_frame) return;
    img[mrow % 3][mcol] = pix;
    if (mrow >= 2 && mcol >= 2) begin
      s = 0;
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          s += act[3*rr + cc] * img[(mrow - 2 + rr) % 3][mcol - 2 + cc];
`ifdef CONV3X3_ABS_EN
      if (s < 0) s = -s;
`endif
      r.data = s; r.eol = (mcol == IMG_W - 1);
      exp_q.push_back(r);
    end
    mcol++;
    if (mcol == IMG_W) begin mcol = 0; mrow++; end
  endtask

  // Called just before each rising edge: score outputs, then advance the model.
  task automatic observe();
    int got;
    res_t r;
    last_beat = 1'b0;
    if (!rst_n) begin model_reset(); prev_stall = 1'b0; return; end
    chk("in_ready_rule", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
    if (prev_stall) chk("hold_valid", int'(bus.out_valid), 1);
    got = int'($signed(bus.out_data));
    if (bus.out_valid && bus.out_ready) begin
      xfer_cnt++; xfer_total++;
      $display("xfer %0d: data=%0d eol=%0b", xfer_total, got, bus.out_eol);
      chk("spurious_result", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        chk("out_data", got, r.data);
        chk("out_eol", int'(bus.out_eol), int'(r.eol));
      end
      if (tbl_on) begin
        if (got != tbl_exp) tbl_bad++;
        if (bus.out_eol) eol_cnt++;
      end
    end else if (bus.out_valid && exp_q.size() != 0) begin
      chk("stall_data", got, exp_q[0].data);
      chk("stall_eol", int'(bus.out_eol), int'(exp_q[0].eol));
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    if (bus.coef_wr && bus.coef_addr < 4'd9)
      shadow[int'(bus.coef_addr)] = int'($signed(bus.coef_data));
    if (bus.in_valid && bus.in_ready) begin
      last_beat = 1'b1;
      model_beat(int'(bus.in_data), bus.in_sof);
    end
  endtask

  task automatic tick();
    #4;
    observe();
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;
    bus.coef_wr = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic push_pix(input int pix, input bit sof);
    int n;
    bus.in_valid = 1'b1; bus.in_sof = sof; bus.in_data = DATA_W'(pix);
    n = 0;
    do begin tick(); n++; end while (!last_beat && n < 50);
    if (!last_beat) chk("accept_timeout", int'(last_beat), 1);
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    repeat (4) tick();
  endtask

  function automatic int pix_of(input int mode, input int c);
    case (mode)
      0:       return 100;
      1:       return 10 * c;
      default: return 4095;
    endcase
  endfunction

  initial begin
    tbl[0] = '{sof: 1'b1, wr_ones: 1'b0, mode: 0, rows: 5, exp_val: 0,        exp_cnt: 18};
    tbl[1] = '{sof: 1'b1, wr_ones: 1'b0, mode: 1, rows: 5, exp_val: RAMP_EXP, exp_cnt: 18};
    tbl[2] = '{sof: 1'b0, wr_ones: 1'b1, mode: 1, rows: 1, exp_val: RAMP_EXP, exp_cnt: 6};
    tbl[3] = '{sof: 1'b1, wr_ones: 1'b0, mode: 2, rows: 5, exp_val: 36855,    exp_cnt: 18};
    xfer_cnt = 0; xfer_total = 0; eol_cnt = 0; tbl_bad = 0; tbl_exp = 0;
    tbl_on = 1'b0; prev_stall = 1'b0; last_beat = 1'b0;
    model_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_data", int'($signed(bus.out_data)), 0);
    chk("reset_out_eol", int'(bus.out_eol), 0);

    for (int i = 0; i < 4; i++) begin
      tbl_on = 1'b1; xfer_cnt = 0; eol_cnt = 0; tbl_bad = 0; tbl_exp = tbl[i].exp_val;
      if (tbl[i].wr_ones) begin
        for (int k = 0; k < 9; k++) begin
          bus.coef_wr = 1'b1; bus.coef_addr = 4'(k); bus.coef_data = COEF_W'(1);
          tick();
        end
        bus.coef_wr = 1'b0;
      end
      for (int r = 0; r < tbl[i].rows; r++)
        for (int c = 0; c < IMG_W; c++)
          push_pix(pix_of(tbl[i].mode, c), tbl[i].sof && r == 0 && c == 0);
      drain();
      chk("tbl_count", xfer_cnt, tbl[i].exp_cnt);
      chk("tbl_values", tbl_bad, 0);
      chk("tbl_eol_count", eol_cnt, tbl[i].exp_cnt / (IMG_W - 2));
      $display("vector %0d: %0d results, expected value %0d", i, xfer_cnt, tbl_exp);
      tbl_on = 1'b0;
    end

    // Backpressure: hold out_ready low for 5 cycles mid-row with a pixel waiting.
    xfer_cnt = 0;
    for (int n = 0; n < 3 * IMG_W; n++) begin
      if (n == 2 * IMG_W + 4) begin
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = DATA_W'(pix_of(1, n % IMG_W));
        repeat (5) begin
          tick();
          chk("bp_in_ready_low", int'(bus.in_ready), 0);
          chk("bp_out_valid_high", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
      end
      push_pix(pix_of(1, n % IMG_W), n == 0);
    end
    drain();
    chk("bp_result_count", xfer_cnt, 6);

    // New frame arrives mid-RUN: two quiet rows, then a normal row.
    for (int c = 0; c < 3; c++) push_pix(pix_of(1, c), 1'b0);
    push_pix(pix_of(1, 0), 1'b1);
    xfer_cnt = 0;
    for (int n = 1; n < 2 * IMG_W; n++) push_pix(pix_of(1, n % IMG_W), 1'b0);
    tick();
    chk("sof_fill_quiet", xfer_cnt, 0);
    for (int c = 0; c < IMG_W; c++) push_pix(pix_of(1, c), 1'b0);
    drain();
    chk("sof_row2_count", xfer_cnt, 6);

    // Reset mid-frame with a result pending.
    for (int n = 0; n < 2 * IMG_W + 5; n++) push_pix(pix_of(1, n % IMG_W), n == 0);
    chk("pre_reset_valid", int'(bus.out_valid), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_out_data", int'($signed(bus.out_data)), 0);
    chk("midrst_out_eol", int'(bus.out_eol), 0);

    // Beats before any in_sof are dropped.
    xfer_cnt = 0;
    for (int n = 0; n < 3 * IMG_W; n++) push_pix(pix_of(1, n % IMG_W), 1'b0);
    drain();
    chk("pre_sof_dropped", xfer_cnt, 0);

    // Kernel back to Sobel-V after reset: flat frame gives zeros.
    tbl_on = 1'b1; xfer_cnt = 0; tbl_bad = 0; eol_cnt = 0; tbl_exp = 0;
    for (int n = 0; n < 3 * IMG_W; n++) push_pix(100, n == 0);
    drain();
    tbl_on = 1'b0;
    chk("reset_kernel_count", xfer_cnt, 6);
    chk("reset_kernel_values", tbl_bad, 0);

    // Randomized traffic against the reference model.
    push_pix(int'($urandom_range(0, 4095)), 1'b1);
    for (int i = 0; i < 4000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = DATA_W'($urandom);
      bus.in_sof    = ($urandom_range(0, 199) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.coef_wr   = ($urandom_range(0, 39) == 0);
      bus.coef_addr = 4'($urandom);
      bus.coef_data = COEF_W'($urandom);
      tick();
    end
    set_idle();
    repeat (5) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
